sfx_sequencer: RTL

- Sound-effect generator driving the speaker pin (uio_out[7]).
- Consumes the game event pulses from player control and score logic: jump, game over and score milestone.
- Plays a short multi-note square-wave sequence per event, with fixed priority and pre-emption.
- Sits directly downstream of player_controller and ScoreModule.

---
 rtl/sfx_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sfx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sfx_sequencer
// Description : Event-driven square-wave sound-effect player with fixed
//               priority (game over > milestone > jump) and pre-emption.
// Revision    : 1.0 - initial release
// ============================================================================
module sfx_sequencer #(
    parameter int NOTE_LEN = 1573438,
    parameter int HP0      = 57216,
    parameter int HP1      = 28608,
    parameter int HP2      = 19072,
    parameter int HP3      = 14304
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_jump_pulse,
    input  logic       i_milestone_pulse,
    input  logic       i_game_over_pulse,
    input  logic       i_mute,
    output logic       o_sound,
    output logic       o_busy,
    output logic [1:0] o_sfx_id
);

    localparam int c_HP_MAX_01 = (HP0 > HP1) ? HP0 : HP1;
    localparam int c_HP_MAX_23 = (HP2 > HP3) ? HP2 : HP3;
    localparam int c_HP_MAX    = (c_HP_MAX_01 > c_HP_MAX_23) ? c_HP_MAX_01 : c_HP_MAX_23;
    localparam int c_TW        = $clog2(c_HP_MAX);
    localparam int c_NW        = $clog2(NOTE_LEN);

    localparam logic [c_TW-1:0] c_HP0_M1   = c_TW'(HP0 - 1);
    localparam logic [c_TW-1:0] c_HP1_M1   = c_TW'(HP1 - 1);
    localparam logic [c_TW-1:0] c_HP2_M1   = c_TW'(HP2 - 1);
    localparam logic [c_TW-1:0] c_HP3_M1   = c_TW'(HP3 - 1);
    localparam logic [c_NW-1:0] c_NOTE_M1  = c_NW'(NOTE_LEN - 1);
    localparam logic [c_TW-1:0] c_TONE_ONE = c_TW'(1);
    localparam logic [c_NW-1:0] c_NOTE_ONE = c_NW'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_sfx, w_sfx_nxt;
    logic [1:0]      r_step, w_step_nxt;
    logic [c_TW-1:0] r_tone_cnt, w_tone_nxt;
    logic [c_NW-1:0] r_note_cnt, w_note_nxt;
    logic            r_square, w_square_nxt;

    logic [1:0]      w_req_id;
    logic [1:0]      w_note_idx;
    logic [1:0]      w_last_step;
    logic [c_TW-1:0] w_hp_m1;

    assign w_req_id = i_game_over_pulse ? 2'd3 :
                      i_milestone_pulse ? 2'd2 :
                      i_jump_pulse      ? 2'd1 : 2'd0;

    // Per-effect note tables: jump 1,3 / milestone 3,2,3 / game over 2,1,0,0
    always_comb begin
        w_note_idx  = 2'd0;
        w_last_step = 2'd0;
        case (r_sfx)
            2'd1: begin
                w_last_step = 2'd1;
                w_note_idx  = (r_step == 2'd0) ? 2'd1 : 2'd3;
            end
            2'd2: begin
                w_last_step = 2'd2;
                w_note_idx  = (r_step == 2'd1) ? 2'd2 : 2'd3;
            end
            2'd3: begin
                w_last_step = 2'd3;
                case (r_step)
                    2'd0:    w_note_idx = 2'd2;
                    2'd1:    w_note_idx = 2'd1;
                    default: w_note_idx = 2'd0;
                endcase
            end
            default: begin
                w_last_step = 2'd0;
                w_note_idx  = 2'd0;
            end
        endcase
    end

    always_comb begin
        case (w_note_idx)
            2'd0:    w_hp_m1 = c_HP0_M1;
            2'd1:    w_hp_m1 = c_HP1_M1;
            2'd2:    w_hp_m1 = c_HP2_M1;
            default: w_hp_m1 = c_HP3_M1;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sfx_nxt    = r_sfx;
        w_step_nxt   = r_step;
        w_tone_nxt   = r_tone_cnt;
        w_note_nxt   = r_note_cnt;
        w_square_nxt = r_square;
        case (r_state)
            S_IDLE: begin
                if (w_req_id != 2'd0) begin
                    w_state_nxt  = S_PLAY;
                    w_sfx_nxt    = w_req_id;
                    w_step_nxt   = 2'd0;
                    w_tone_nxt   = '0;
                    w_note_nxt   = '0;
                    w_square_nxt = 1'b0;
                end
            end
            S_PLAY: begin
                // A strictly higher-priority event wins even on the last cycle
                if (w_req_id > r_sfx) begin
                    w_sfx_nxt    = w_req_id;
                    w_step_nxt   = 2'd0;
                    w_tone_nxt   = '0;
                    w_note_nxt   = '0;
                    w_square_nxt = 1'b0;
                end else if (r_note_cnt == c_NOTE_M1) begin
                    w_note_nxt   = '0;
                    w_tone_nxt   = '0;
                    w_square_nxt = 1'b0;
                    if (r_step == w_last_step) begin
                        w_state_nxt = S_IDLE;
                        w_sfx_nxt   = 2'd0;
                        w_step_nxt  = 2'd0;
                    end else begin
                        w_step_nxt = r_step + 2'd1;
                    end
                end else begin
                    w_note_nxt = r_note_cnt + c_NOTE_ONE;
                    if (r_tone_cnt == w_hp_m1) begin
                        w_tone_nxt   = '0;
                        w_square_nxt = ~r_square;
                    end else begin
                        w_tone_nxt = r_tone_cnt + c_TONE_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sfx      <= 2'd0;
            r_step     <= 2'd0;
            r_tone_cnt <= '0;
            r_note_cnt <= '0;
            r_square   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sfx      <= w_sfx_nxt;
            r_step     <= w_step_nxt;
            r_tone_cnt <= w_tone_nxt;
            r_note_cnt <= w_note_nxt;
            r_square   <= w_square_nxt;
        end
    end

    assign o_sound  = r_square & ~i_mute;
    assign o_busy   = (r_state == S_PLAY);
    assign o_sfx_id = r_sfx;

endmodule
`default_nettype wire
